// File: rtl/vga_pixel_gen.sv
// Pixel generator between the VGA timing counter and the DAC: black, red-frame test
// pattern, camera stream and colour bars, with syncs delayed to match the camera fetch.
module vga_pixel_gen #(
    parameter int COLOR_W     = 3,
    parameter int H_ACT_START = 160,
    parameter int H_ACT_END   = 799,
    parameter int V_ACT_START = 41,
    parameter int V_ACT_END   = 520,
    parameter int FRAME_W     = 10,
    parameter int BAR_W       = 80,
    parameter int READ_LAT    = 1
) (
    input  logic               clk_25,
    input  logic               rst_n,
    input  logic [9:0]         h_count_i,
    input  logic [9:0]         v_count_i,
    input  logic               bright_i,
    input  logic               hsync_in_i,
    input  logic               vsync_in_i,
    input  logic [1:0]         mode_i,
    input  logic [COLOR_W-1:0] data_i,
    input  logic               data_valid_i,
    output logic               read_o,
    output logic [COLOR_W-1:0] rgb_o,
    output logic               hsync_out_o,
    output logic               vsync_out_o,
    output logic               underflow_o,
    output logic [15:0]        underflow_cnt_o
);

    localparam int L  = READ_LAT + 2;
    localparam int D  = L - 1;
    localparam int F  = COLOR_W / 3;
    localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [9:0]    H_START  = 10'(H_ACT_START);
    localparam logic [9:0]    H_RED_LO = 10'(H_ACT_START + FRAME_W);
    localparam logic [9:0]    H_RED_HI = 10'(H_ACT_END - FRAME_W);
    localparam logic [9:0]    V_RED_LO = 10'(V_ACT_START + FRAME_W);
    localparam logic [9:0]    V_RED_HI = 10'(V_ACT_END - FRAME_W);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    localparam logic [COLOR_W-1:0] C_RED     = {{F{1'b1}}, {(2*F){1'b0}}};
    localparam logic [COLOR_W-1:0] C_WHITE   = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] C_MAGENTA = {{F{1'b1}}, {F{1'b0}}, {F{1'b1}}};

    typedef enum logic [1:0] {
        MODE_BLACK  = 2'b00,
        MODE_FRAME  = 2'b01,
        MODE_CAMERA = 2'b10,
        MODE_BARS   = 2'b11
    } mode_e;

    mode_e               mode_q, mode_d;
    logic                read_q, read_d;
    logic [2:0]          bar_idx_q, bar_idx_d, idx_cur;
    logic [BW-1:0]       bar_cnt_q, bar_cnt_d, cnt_cur;
    logic [COLOR_W-1:0]  color0;
    logic [COLOR_W-1:0]  col_q    [D];
    logic                bright_q [D];
    mode_e               mode_p_q [D];
    logic                hs_q     [L];
    logic                vs_q     [L];
    logic [COLOR_W-1:0]  rgb_q, rgb_d;
    logic                uf_now, vs_fall;
    logic                underflow_q, underflow_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [15:0]         ucnt_q, ucnt_d;

    // Stage 0: mode latch, bar counter and colour from the current counter sample.
    always_comb begin
        mode_d    = mode_q;
        read_d    = bright_i && (mode_q == MODE_CAMERA);
        idx_cur   = (h_count_i == H_START) ? 3'd0 : bar_idx_q;
        cnt_cur   = (h_count_i == H_START) ? '0 : bar_cnt_q;
        bar_idx_d = idx_cur;
        bar_cnt_d = cnt_cur;
        color0    = '0;
        if (h_count_i == 10'd0 && v_count_i == 10'd0) begin
            mode_d = mode_e'(mode_i);
        end
        if (bright_i) begin
            if (cnt_cur == BAR_LAST) begin
                bar_cnt_d = '0;
                bar_idx_d = idx_cur + 3'd1;
            end else begin
                bar_cnt_d = cnt_cur + BW'(1);
            end
            case (mode_q)
                MODE_FRAME: begin
                    if (h_count_i < H_RED_LO || h_count_i > H_RED_HI ||
                        v_count_i < V_RED_LO || v_count_i > V_RED_HI) begin
                        color0 = C_RED;
                    end else begin
                        color0 = C_WHITE;
                    end
                end
                MODE_BARS: color0 = {{F{idx_cur[2]}}, {F{idx_cur[1]}}, {F{idx_cur[0]}}};
                default:   color0 = '0;
            endcase
        end
    end

    // Final stage: camera data arrives READ_LAT cycles after the read strobe is sampled.
    always_comb begin
        rgb_d       = col_q[D-1];
        uf_now      = 1'b0;
        vs_fall     = vs_q[L-1] && !vs_q[L-2];
        frame_cnt_d = frame_cnt_q;
        underflow_d = underflow_q;
        ucnt_d      = ucnt_q;
        if (mode_p_q[D-1] == MODE_CAMERA) begin
            rgb_d = '0;
            if (bright_q[D-1]) begin
                if (data_valid_i) begin
                    rgb_d = data_i;
                end else begin
                    rgb_d  = C_MAGENTA;
                    uf_now = 1'b1;
                end
            end
        end
        if (vs_fall) begin
            ucnt_d      = frame_cnt_q;
            frame_cnt_d = {15'd0, uf_now};
            underflow_d = uf_now;
        end else if (uf_now) begin
            underflow_d = 1'b1;
            if (frame_cnt_q != 16'hFFFF) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_BLACK;
            read_q      <= 1'b0;
            bar_idx_q   <= '0;
            bar_cnt_q   <= '0;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
            frame_cnt_q <= '0;
            ucnt_q      <= '0;
            for (int i = 0; i < D; i++) begin
                col_q[i]    <= '0;
                bright_q[i] <= 1'b0;
                mode_p_q[i] <= MODE_BLACK;
            end
            for (int i = 0; i < L; i++) begin
                hs_q[i] <= 1'b1;
                vs_q[i] <= 1'b1;
            end
        end else begin
            mode_q      <= mode_d;
            read_q      <= read_d;
            bar_idx_q   <= bar_idx_d;
            bar_cnt_q   <= bar_cnt_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
            frame_cnt_q <= frame_cnt_d;
            ucnt_q      <= ucnt_d;
            col_q[0]    <= color0;
            bright_q[0] <= bright_i;
            mode_p_q[0] <= mode_q;
            for (int i = 1; i < D; i++) begin
                col_q[i]    <= col_q[i-1];
                bright_q[i] <= bright_q[i-1];
                mode_p_q[i] <= mode_p_q[i-1];
            end
            hs_q[0] <= hsync_in_i;
            vs_q[0] <= vsync_in_i;
            for (int i = 1; i < L; i++) begin
                hs_q[i] <= hs_q[i-1];
                vs_q[i] <= vs_q[i-1];
            end
        end
    end

    assign read_o          = read_q;
    assign rgb_o           = rgb_q;
    assign hsync_out_o     = hs_q[L-1];
    assign vsync_out_o     = vs_q[L-1];
    assign underflow_o     = underflow_q;
    assign underflow_cnt_o = ucnt_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Bench for vga_pixel_gen: drives compressed 640x480 frames, models the frame-buffer
// memory and checks every output pixel and sync against an expected queue.
module tb_vga_pixel_gen;

    localparam int COLOR_W = 3;
    localparam int L       = 3;
    localparam int W       = COLOR_W + 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [9:0]         h_count = '0;
    logic [9:0]         v_count = '0;
    logic               bright = 1'b0;
    logic               hsync_in = 1'b1;
    logic               vsync_in = 1'b1;
    logic [1:0]         mode_sel = 2'b01;
    logic [COLOR_W-1:0] data = '0;
    logic               data_valid = 1'b0;
    logic               read_o;
    logic [COLOR_W-1:0] rgb_o;
    logic               hsync_out, vsync_out, underflow;
    logic [15:0]        underflow_cnt;

    vga_pixel_gen dut (
        .clk_25          (clk),
        .rst_n           (rst_n),
        .h_count_i       (h_count),
        .v_count_i       (v_count),
        .bright_i        (bright),
        .hsync_in_i      (hsync_in),
        .vsync_in_i      (vsync_in),
        .mode_i          (mode_sel),
        .data_i          (data),
        .data_valid_i    (data_valid),
        .read_o          (read_o),
        .rgb_o           (rgb_o),
        .hsync_out_o     (hsync_out),
        .vsync_out_o     (vsync_out),
        .underflow_o     (underflow),
        .underflow_cnt_o (underflow_cnt)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard entries are {underflow_pixel, rgb, hsync, vsync}.
    logic [W-1:0]       exp_q[$];
    logic [COLOR_W:0]   mem_q[$];
    logic [1:0]         model_mode = 2'b00;
    bit                 mon_en = 1'b0;
    bit                 m_prev_vs = 1'b1;
    bit                 m_sticky = 1'b0;
    int                 m_frame_cnt = 0;
    int                 m_last_cnt = 0;

    // Frame-buffer memory with one cycle of read latency.
    always @(posedge clk) begin
        if (read_o && mem_q.size() > 0) begin
            logic [COLOR_W:0] m;
            m = mem_q.pop_front();
            data       <= m[COLOR_W-1:0];
            data_valid <= m[COLOR_W];
        end else begin
            data_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_en && exp_q.size() > L) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check_eq("pix", {rgb_o, hsync_out, vsync_out}, e[W-2:0]);
            if (m_prev_vs && !e[0]) begin
                m_last_cnt  = m_frame_cnt;
                m_frame_cnt = e[W-1] ? 1 : 0;
                m_sticky    = e[W-1];
            end else if (e[W-1]) begin
                if (m_frame_cnt < 65535) m_frame_cnt++;
                m_sticky = 1'b1;
            end
            m_prev_vs = e[0];
            check_eq("underflow", underflow, m_sticky);
            check_eq("ucnt", underflow_cnt, m_last_cnt);
        end
    end

    task automatic drive_pix(input int h, input int v, input bit valid);
        bit                 b, hs, vs, uf, e_read;
        logic [COLOR_W-1:0] c;
        int                 idx;
        b  = (h >= 160 && h <= 799 && v >= 41 && v <= 520);
        hs = !(h < 96);
        vs = !(v < 2);
        uf = 1'b0;
        c  = '0;
        if (b) begin
            case (model_mode)
                2'b01: c = (h < 170 || h > 789 || v < 51 || v > 510) ? 3'b100 : 3'b111;
                2'b11: begin
                    idx = ((h - 160) / 80) % 8;
                    c   = idx[2:0];
                end
                2'b10: begin
                    c  = valid ? 3'(h % 8) : 3'b101;
                    uf = !valid;
                    mem_q.push_back({valid, 3'(h % 8)});
                end
                default: c = '0;
            endcase
        end
        e_read = b && (model_mode == 2'b10);
        h_count  = 10'(h);
        v_count  = 10'(v);
        bright   = b;
        hsync_in = hs;
        vsync_in = vs;
        exp_q.push_back({uf, c, hs, vs});
        if (h == 0 && v == 0) model_mode = mode_sel;
        @(posedge clk);
        #1;
        check_eq("read", read_o, e_read);
    endtask

    task automatic drive_line(input int v, input int uf_lo, input int uf_hi);
        for (int h = 0; h < 800; h++) drive_pix(h, v, !(h >= uf_lo && h <= uf_hi));
    endtask

    task automatic drive_frame(input int uf_lo, input int uf_hi);
        int lines[5] = '{0, 1, 41, 61, 520};
        for (int i = 0; i < 5; i++) drive_line(lines[i], (lines[i] == 61) ? uf_lo : 1000, uf_hi);
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #3;
        check_eq("rst_rgb", rgb_o, 0);
        check_eq("rst_read", read_o, 0);
        check_eq("rst_hs", hsync_out, 1);
        check_eq("rst_vs", vsync_out, 1);
        check_eq("rst_uf", underflow, 0);
        check_eq("rst_ucnt", underflow_cnt, 0);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Partial frame after reset stays black; next frame is the red-frame pattern.
        drive_line(41, 1000, 0);
        mode_sel = 2'b01;
        drive_frame(1000, 0);

        mode_sel = 2'b10;
        drive_frame(1000, 0);

        mode_sel = 2'b11;
        drive_frame(1000, 0);

        // Switch requested mid-frame; camera starts only with the next frame.
        mode_sel = 2'b01;
        drive_line(0, 1000, 0);
        drive_line(1, 1000, 0);
        drive_line(41, 1000, 0);
        mode_sel = 2'b10;
        drive_line(200, 1000, 0);
        drive_line(300, 1000, 0);
        drive_line(520, 1000, 0);
        drive_frame(1000, 0);

        // Five underflow pixels on one line, then publish the count at the next frame.
        drive_frame(300, 304);
        check_eq("uf_set", underflow, 1);
        drive_line(0, 1000, 0);
        check_eq("ucnt_frame", underflow_cnt, 5);
        check_eq("uf_clear", underflow, 0);
        drive_line(1, 1000, 0);
        for (int h = 0; h < 400; h++) drive_pix(h, 41, 1'b1);

        // Asynchronous reset pulse mid-line in camera mode.
        mon_en = 1'b0;
        #5;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rgb", rgb_o, 0);
        check_eq("arst_read", read_o, 0);
        check_eq("arst_ucnt", underflow_cnt, 0);
        check_eq("arst_uf", underflow, 0);
        check_eq("arst_hs", hsync_out, 1);
        check_eq("arst_vs", vsync_out, 1);
        @(posedge clk);
        @(posedge clk);
        #5;
        rst_n = 1'b1;
        exp_q.delete();
        mem_q.delete();
        model_mode  = 2'b00;
        m_prev_vs   = 1'b1;
        m_sticky    = 1'b0;
        m_frame_cnt = 0;
        m_last_cnt  = 0;
        mon_en      = 1'b1;
        for (int h = 400; h < 800; h++) drive_pix(h, 41, 1'b1);
        drive_line(61, 1000, 0);
        drive_frame(1000, 0);
        for (int i = 0; i < L + 2; i++) drive_pix(5, 5, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
